// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the digit/row scan controller: FSM state encoding and
// default timing for a 100 MHz clock and 1 kHz slot rate.
package digit_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int DEF_N     = 3;
  localparam int DEF_DIV   = 100000;
  localparam int DEF_BLANK = 1000;
  localparam int DEF_CW    = 17;

endpackage

// File: rtl/digit_scan_ctrl_next_idx.sv
// Rotating priority finder: lowest set mask bit at or after a start index,
// wrapping around. Exclusive mode starts one past cur, so cur is checked last.
module scan_next_idx #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] mask,
  input  logic [N-1:0]    cur,
  input  logic            incl,
  output logic [N-1:0]    idx,
  output logic            vld
);

  logic [N-1:0] start;
  logic [N-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    start = incl ? cur : cur + N'(1);
    cand  = start;
    idx   = cur;
    vld   = |mask;
    for (int k = 2**N - 1; k >= 0; k--) begin
      cand = start + N'(k);
      if (mask[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan controller driving an N-to-2^N decoder: blank gap, then a lit slot,
// stepping through the masked-in slots. All outputs are registered.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DIV   = DEF_DIV,
  parameter int BLANK = DEF_BLANK,
  parameter int CW    = DEF_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [2**N-1:0] mask,
  output logic [N-1:0]    sel,
  output logic            en,
  output logic            slot_tick
);

  scan_state_t  state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  find_idx;
  logic          any_set;
  logic          find_incl;

  // Inclusive search (first_idx) everywhere except leaving a lit slot (next_idx).
  assign find_incl = (state != ST_SHOW);

  scan_next_idx #(.N(N)) u_find (
    .mask (mask),
    .cur  (sel),
    .incl (find_incl),
    .idx  (find_idx),
    .vld  (any_set)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sel       <= '0;
      en        <= 1'b0;
      slot_tick <= 1'b0;
    end else begin
      slot_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          en  <= 1'b0;
          cnt <= '0;
          if (run && any_set) begin
            state <= ST_BLANK;
            sel   <= find_idx;
          end
        end
        ST_BLANK: begin
          if (!run || !any_set) begin
            state <= ST_IDLE;
            cnt   <= '0;
            en    <= 1'b0;
          end else if (!mask[sel]) begin
            // Retarget without restarting the gap; hold at terminal so the
            // gap still ends on the next edge with the new slot.
            sel <= find_idx;
            if (cnt != CW'(BLANK - 1)) cnt <= cnt + CW'(1);
          end else if (cnt == CW'(BLANK - 1)) begin
            state <= ST_SHOW;
            cnt   <= '0;
            en    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (!run || !any_set) begin
            state <= ST_IDLE;
            cnt   <= '0;
            en    <= 1'b0;
          end else if (!mask[sel] || cnt == CW'(DIV - 1)) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            en        <= 1'b0;
            sel       <= find_idx;
            slot_tick <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          en    <= 1'b0;
        end
      endcase
    end
  end

endmodule
